// File: rtl/loader_pkg.sv
// Shared types and sizing constants for the program loader.
// Holds the load FSM state enum and default widths.
package loader_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  // Length byte 0 encodes a full 2**ADDR_W image,
  // so the byte counter needs one extra bit.
  localparam int CNT_W_DEF  = ADDR_W_DEF + 1;

  typedef enum logic [2:0] {
    LOAD_LEN,
    LOAD_DATA,
    LOAD_CSUM,
    LOAD_DONE,
    LOAD_ERR
  } loadState_t;

  function automatic int cntWidth(input int addrW);
    return addrW + 1;
  endfunction

  function automatic logic isStreaming(
    input loadState_t s
  );
    return (s == LOAD_LEN) ||
           (s == LOAD_DATA) ||
           (s == LOAD_CSUM);
  endfunction

endpackage

// File: rtl/prog_ram.sv
// Program RAM: 2**ADDR_W x DATA_W, one sync write, one async read.
// Ports: clk; we/waddr/wdata write port; raddr -> rdata read port.
module prog_ram
  import loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately never cleared by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-cycle read of the address being written
  // returns the old value.
  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Program loader: byte stream -> RAM, holds CPU in reset until checksum ok.
// Ports: clk, rst (sync, active-low); in_data/in_valid/in_ready stream;
// mem_addr -> mem_val async read; cpu_rst, load_done, load_err status.
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_val,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam int CNT_W = cntWidth(ADDR_W);

  loadState_t        state;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] wrPtr;
  logic [DATA_W-1:0] acc;

  logic              xfer;
  logic              wrEn;
  logic [CNT_W-1:0]  lenVal;
  logic [DATA_W-1:0] csumSum;

  // rst is folded in so no RAM write can slip
  // through on a reset edge.
  assign xfer    = rst & in_valid & in_ready;
  assign wrEn    = xfer & (state == LOAD_DATA);
  assign csumSum = acc + in_data;

  // Length 0 stands for a full-depth image.
  always_comb begin
    lenVal = CNT_W'(in_data);
    if (lenVal == '0) begin
      lenVal = CNT_W'(1) << ADDR_W;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= LOAD_LEN;
      count     <= '0;
      wrPtr     <= '0;
      acc       <= '0;
      in_ready  <= 1'b0;
      cpu_rst   <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      unique case (state)
        LOAD_LEN: begin
          in_ready <= 1'b1;
          if (xfer) begin
            count <= lenVal;
            wrPtr <= '0;
            acc   <= '0;
            state <= LOAD_DATA;
          end
        end
        LOAD_DATA: begin
          in_ready <= 1'b1;
          if (xfer) begin
            acc   <= acc + in_data;
            wrPtr <= wrPtr + ADDR_W'(1);
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
              state <= LOAD_CSUM;
            end
          end
        end
        LOAD_CSUM: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (csumSum == '0) begin
              state     <= LOAD_DONE;
              cpu_rst   <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state    <= LOAD_ERR;
              load_err <= 1'b1;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        LOAD_DONE, LOAD_ERR: begin
          in_ready <= 1'b0;
        end
        default: begin
          // Unreachable encodings park safely with CPU held.
          state    <= LOAD_ERR;
          in_ready <= 1'b0;
          load_err <= 1'b1;
        end
      endcase
    end
  end

  prog_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) uRam (
    .clk   (clk),
    .we    (wrEn),
    .waddr (wrPtr),
    .wdata (in_data),
    .raddr (mem_addr),
    .rdata (mem_val)
  );

endmodule
